// File: rtl/stream_pkt_gen.sv
// Valid/ready packet stimulus source: pkt_num packets of pkt_len beats, incrementing or LFSR payload (PKT_GEN_LFSR_EN).
// Latency: start accepted at edge N -> first beat valid in cycle N+1; done pulses the cycle after the final handshake.
// Backpressure: m_valid never waits on m_ready; data/last hold while stalled; no bubbles between beats or packets.
module stream_pkt_gen #(
    parameter int          DATA_W        = 32,
    parameter int          LEN_W         = 16,
    parameter int          WARMUP_CYCLES = 5,
    parameter logic [31:0] LFSR_SEED     = 32'hACE10001
) (
    input  logic              clk_,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [LEN_W-1:0]  pkt_num,
    output logic              ready_o,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [LEN_W-1:0]  pkt_cnt
);

    typedef enum logic [1:0] {S_WARMUP, S_IDLE, S_SEND, S_DONE} state_t;

    localparam logic [31:0] WARM = WARMUP_CYCLES[31:0];

    state_t             r_state;
    logic [31:0]        r_wcnt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_num;
    logic [LEN_W-1:0]   r_beat;
    logic [LEN_W-1:0]   r_pkt;
    logic               r_valid;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic               w_hs;
    logic               w_load;
    logic               w_last_beat;
    logic               w_final_pkt;

    assign w_hs        = r_valid && m_ready;
    assign w_load      = (r_state == S_IDLE) && start;
    assign w_last_beat = (r_beat == (r_len - LEN_W'(1)));
    assign w_final_pkt = ((r_pkt + LEN_W'(1)) == r_num);

    assign ready_o = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign m_valid = r_valid;
    assign m_last  = r_valid && w_last_beat;
    assign pkt_cnt = r_pkt;

    // A zero warm-up still spends the first edge here so reset keeps every output low.
    always_ff @(posedge clk_ or negedge rst) begin
        if (!rst) begin
            r_state <= S_WARMUP;
            r_wcnt  <= '0;
            r_len   <= '0;
            r_num   <= '0;
            r_beat  <= '0;
            r_pkt   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_WARMUP: begin
                    if ((r_wcnt + 32'd1) >= WARM) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        r_len   <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
                        r_num   <= pkt_num;
                        r_beat  <= '0;
                        r_pkt   <= '0;
                        r_ready <= 1'b0;
                        if (pkt_num == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SEND;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            r_beat <= '0;
                            r_pkt  <= r_pkt + LEN_W'(1);
                            if (w_final_pkt) begin
                                r_state <= S_DONE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + LEN_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_WARMUP;
            endcase
        end
    end

`ifdef PKT_GEN_LFSR_EN
    logic [31:0] r_lfsr;

    // Right-shifting Galois LFSR; taps folded in when the shifted-out bit is 1.
    always_ff @(posedge clk_ or negedge rst) begin
        if (!rst) begin
            r_lfsr <= '0;
        end else if (w_load) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_hs) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h80200003) : (r_lfsr >> 1);
        end
    end

    assign m_data = r_lfsr[DATA_W-1:0];
`else
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk_ or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= '0;
        end else if (w_hs) begin
            r_data <= r_data + DATA_W'(1);
        end
    end

    assign m_data = r_data;
`endif

endmodule

// File: tb/tb_stream_pkt_gen.sv
// Directed bench for stream_pkt_gen: vector table for steady-state runs plus hand sequences for reset/warm-up and LFSR repeat.
module tb_stream_pkt_gen;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk_    = 1'b0;
    logic          rst     = 1'b0;
    logic          start   = 1'b0;
    logic          m_ready = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic [LW-1:0] pkt_num = '0;
    logic          ready_o, busy, done, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic [LW-1:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    stream_pkt_gen #(.DATA_W(DW), .LEN_W(LW), .WARMUP_CYCLES(5), .LFSR_SEED(32'hACE10001)) dut (
        .clk_    (clk_),
        .rst     (rst),
        .start   (start),
        .pkt_len (pkt_len),
        .pkt_num (pkt_num),
        .ready_o (ready_o),
        .busy    (busy),
        .done    (done),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk_ = ~clk_;

    typedef struct {
        logic          st;
        logic [LW-1:0] len;
        logic [LW-1:0] num;
        logic          rdy;
        logic          v;
        int            d;
        logic          l;
        logic          dn;
        logic          rd;
        logic          bz;
        logic [LW-1:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input int len, input int num, input logic rdy,
                                input logic v, input int d, input logic l, input logic dn,
                                input logic rd, input logic bz, input int pc);
        vec_t r;
        r.st = st; r.len = LW'(len); r.num = LW'(num); r.rdy = rdy;
        r.v = v; r.d = d; r.l = l; r.dn = dn; r.rd = rd; r.bz = bz; r.pc = LW'(pc);
        return r;
    endfunction

    // Payload of the k-th handshake of a run.
    function automatic logic [31:0] exp_data(input int k);
`ifdef PKT_GEN_LFSR_EN
        logic [31:0] s;
        s = 32'hACE10001;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        return s;
`else
        return 32'(k);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input int d, input logic l,
                             input logic dn, input logic rd, input logic bz, input logic [LW-1:0] pc);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(v));
        if (v) chk({tag, ".m_data"}, m_data, exp_data(d));
        chk({tag, ".m_last"},  32'(m_last),  32'(l));
        chk({tag, ".done"},    32'(done),    32'(dn));
        chk({tag, ".ready_o"}, 32'(ready_o), 32'(rd));
        chk({tag, ".busy"},    32'(busy),    32'(bz));
        chk({tag, ".pkt_cnt"}, 32'(pkt_cnt), 32'(pc));
    endtask

    task automatic warmup_seq(input string tag, input logic pulse_start);
        for (int c = 1; c <= 5; c++) begin
            start = pulse_start;
            tick();
            check_out($sformatf("%s.c%0d", tag, c), 1'b0, 0, 1'b0, 1'b0, (c == 5), 1'b0, '0);
        end
        start = 1'b0;
    endtask

    task automatic short_run(input string tag, input logic [31:0] d0, input logic [31:0] d1);
        start = 1'b1; pkt_len = 2; pkt_num = 1; m_ready = 1'b1;
        tick();
        start = 1'b0;
        check_out({tag, ".b0"}, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk({tag, ".b0.lit"}, m_data, d0);
        tick();
        check_out({tag, ".b1"}, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk({tag, ".b1.lit"}, m_data, d1);
        tick();
        check_out({tag, ".done"}, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, LW'(1));
        tick();
        check_out({tag, ".idle"}, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, LW'(1));
    endtask

    logic [31:0] lit0, lit1;

    initial begin
        //       st len num rdy  v  d  l dn rd bz pc
        // len=4 num=2 back-to-back, start ignored in SEND and in DONE
        tbl.push_back(mk(1, 4, 2, 1,  1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 3, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 9, 9, 1,  1, 4, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 5, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 6, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 7, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(1, 3, 0, 1,  0, 0, 0, 0, 1, 0, 2));
        // len=3 num=1 with stalls: ready 1,0,0,1,0,1
        tbl.push_back(mk(1, 3, 1, 0,  1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 2, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 2, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1));
        // num=0 goes straight to DONE; len=0 becomes a single last beat
        tbl.push_back(mk(1, 5, 0, 1,  0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0,  1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1));

        // Reset held, then warm-up with start pulsed every cycle
        repeat (5) tick();
        check_out("rst", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst.m_data", m_data, 32'h0);
        rst = 1'b1;
        warmup_seq("warm", 1'b1);
        tick();
        check_out("warm.noqueue", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            start   = tbl[i].st;
            pkt_len = tbl[i].len;
            pkt_num = tbl[i].num;
            m_ready = tbl[i].rdy;
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].l,
                      tbl[i].dn, tbl[i].rd, tbl[i].bz, tbl[i].pc);
        end
        start = 1'b0;

        // Asynchronous reset after beat 2 of a len=8 packet
        start = 1'b1; pkt_len = 8; pkt_num = 2; m_ready = 1'b1;
        tick();
        start = 1'b0;
        check_out("mid.b0", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        tick();
        check_out("mid.b2", 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        #2 rst = 1'b0;
        #1;
        check_out("mid.rst", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("mid.rst.m_data", m_data, 32'h0);
        repeat (3) tick();
        rst = 1'b1;
        warmup_seq("rewarm", 1'b0);

`ifdef PKT_GEN_LFSR_EN
        lit0 = 32'hACE10001;
        lit1 = 32'hD6508003;
`else
        lit0 = 32'h0;
        lit1 = 32'h1;
`endif
        short_run("run1", lit0, lit1);
        short_run("run2", lit0, lit1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
